// File: rtl/led_fade_pwm_driver.sv
// rtl/led_fade_pwm_driver.sv - 8-LED fade engine with shared-counter PWM output and raw bypass
module led_fade_pwm_driver #(
    parameter int PWM_DIV  = 196,
    parameter int FADE_DIV = 50000,
    parameter int STEP     = 8
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic [7:0] pattern_in,
    input  logic       bypass,
    output logic [7:0] led_out,
    output logic       settled
);

    localparam int PRE_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(PWM_DIV - 1);
    localparam logic [FADE_W-1:0] FADE_MAX = FADE_W'(FADE_DIV - 1);
    localparam logic [8:0]        STEP9    = 9'(STEP);
    localparam logic [7:0]        STEP8    = 8'(STEP);

    logic [7:0]        pattern_reg;
    logic [PRE_W-1:0]  pre_cnt;
    logic [7:0]        pwm_cnt;
    logic [FADE_W-1:0] fade_cnt;
    logic              fade_tick;
    logic [7:0]        level     [8];
    logic [7:0]        level_nxt [8];
    logic [7:0]        led_nxt;
    logic [7:0]        at_target;

    // One fade step toward the target endpoint; the 9-bit sum saturates instead of wrapping
    function automatic logic [7:0] fade_step(input logic [7:0] lvl, input logic tgt);
        logic [8:0] sum;
        sum = {1'b0, lvl} + STEP9;
        if (tgt) begin
            return sum[8] ? 8'hFF : sum[7:0];
        end
        return (lvl > STEP8) ? (lvl - STEP8) : 8'h00;
    endfunction

    assign fade_tick = (fade_cnt == FADE_MAX);
    assign settled   = &at_target;

    // PWM prescaler, shared PWM counter and fade interval counter
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            pre_cnt  <= '0;
            pwm_cnt  <= '0;
            fade_cnt <= '0;
        end else begin
            if (pre_cnt == PRE_MAX) begin
                pre_cnt <= '0;
                pwm_cnt <= pwm_cnt + 8'd1;
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
            fade_cnt <= fade_tick ? '0 : fade_cnt + FADE_W'(1);
        end
    end

    // Per-LED brightness levels move only on fade ticks, also while bypassed
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) level[i] <= 8'h00;
        end else if (fade_tick) begin
            for (int i = 0; i < 8; i++) level[i] <= level_nxt[i];
        end
    end

    // Input capture and registered pin drive
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            pattern_reg <= 8'h00;
            led_out     <= 8'h00;
        end else begin
            pattern_reg <= pattern_in;
            led_out     <= led_nxt;
        end
    end

    // Next level, PWM compare (level 255 forced fully on) and per-LED settled flags
    always_comb begin
        led_nxt   = 8'h00;
        at_target = 8'h00;
        for (int i = 0; i < 8; i++) begin
            level_nxt[i] = fade_step(level[i], pattern_reg[i]);
            if (bypass) begin
                led_nxt[i] = pattern_reg[i];
            end else if (level[i] == 8'hFF) begin
                led_nxt[i] = 1'b1;
            end else begin
                led_nxt[i] = (level[i] > pwm_cnt);
            end
            at_target[i] = (level[i] == (pattern_reg[i] ? 8'hFF : 8'h00));
        end
    end

endmodule

// File: tb/tb_led_fade_pwm_driver.sv
// tb/tb_led_fade_pwm_driver.sv - scoreboard bench for two differently parameterised fade drivers
module tb_led_fade_pwm_driver;

    localparam int A_PWM = 1, A_FADE = 4, A_STEP = 51;
    localparam int B_PWM = 3, B_FADE = 5, B_STEP = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] pattern_in = 8'h00;
    logic       bypass = 1'b0;
    logic [7:0] led_a, led_b;
    logic       settled_a, settled_b;

    always #5 clk = ~clk;

    led_fade_pwm_driver #(.PWM_DIV(A_PWM), .FADE_DIV(A_FADE), .STEP(A_STEP)) u_a (
        .clk_50M(clk), .reset(reset), .pattern_in(pattern_in), .bypass(bypass),
        .led_out(led_a), .settled(settled_a));

    led_fade_pwm_driver #(.PWM_DIV(B_PWM), .FADE_DIV(B_FADE), .STEP(B_STEP)) u_b (
        .clk_50M(clk), .reset(reset), .pattern_in(pattern_in), .bypass(bypass),
        .led_out(led_b), .settled(settled_b));

    typedef struct {
        logic [7:0] led_a;
        logic       set_a;
        logic [7:0] led_b;
        logic       set_b;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;

    // Reference state: elapsed clocks since reset, target bits and integer brightness
    bit         model_valid = 0;
    int         m_t    [2];
    int         m_lvl  [2][8];
    logic [7:0] m_preg [2];
    logic [7:0] m_led  [2];

    // Advance the reference by the clock edge that will sample the inputs just driven
    task automatic model_edge();
        exp_t e;
        int   pd, fd, st, pwm;
        bit   tick;
        bit   s [2];
        if (reset) begin
            model_valid = 1;
            for (int k = 0; k < 2; k++) begin
                m_t[k] = 0;
                m_preg[k] = 8'h00;
                m_led[k] = 8'h00;
                for (int i = 0; i < 8; i++) m_lvl[k][i] = 0;
            end
        end else if (model_valid) begin
            for (int k = 0; k < 2; k++) begin
                pd   = (k == 0) ? A_PWM : B_PWM;
                fd   = (k == 0) ? A_FADE : B_FADE;
                st   = (k == 0) ? A_STEP : B_STEP;
                pwm  = (m_t[k] / pd) % 256;
                tick = (m_t[k] % fd) == (fd - 1);
                for (int i = 0; i < 8; i++) begin
                    if (bypass)                m_led[k][i] = m_preg[k][i];
                    else if (m_lvl[k][i] == 255) m_led[k][i] = 1'b1;
                    else                       m_led[k][i] = (m_lvl[k][i] > pwm);
                end
                if (tick) begin
                    for (int i = 0; i < 8; i++) begin
                        if (m_preg[k][i]) m_lvl[k][i] = (m_lvl[k][i] + st > 255) ? 255 : m_lvl[k][i] + st;
                        else              m_lvl[k][i] = (m_lvl[k][i] - st < 0) ? 0 : m_lvl[k][i] - st;
                    end
                end
                m_preg[k] = pattern_in;
                m_t[k]++;
            end
        end
        if (!model_valid) return;
        for (int k = 0; k < 2; k++) begin
            s[k] = 1;
            for (int i = 0; i < 8; i++)
                if (m_lvl[k][i] != (m_preg[k][i] ? 255 : 0)) s[k] = 0;
        end
        e.led_a = m_led[0];
        e.set_a = s[0];
        e.led_b = m_led[1];
        e.set_b = s[1];
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rst, input logic [7:0] pat, input logic byp);
        @(negedge clk);
        reset = rst;
        pattern_in = pat;
        bypass = byp;
        model_edge();
    endtask

    task automatic hold(input int n, input logic rst, input logic [7:0] pat, input logic byp);
        for (int j = 0; j < n; j++) step(rst, pat, byp);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, want);
        end
    endtask

    // Monitor: one expected entry per clock edge, compared just after that edge
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("led_out_a", led_a, e.led_a);
            check("settled_a", {7'd0, settled_a}, {7'd0, e.set_a});
            check("led_out_b", led_b, e.led_b);
            check("settled_b", {7'd0, settled_b}, {7'd0, e.set_b});
        end
    end

    initial begin
        logic [7:0] pat;
        logic       byp;
        int         len;

        // Reset held with all targets high, then release
        hold(3, 1'b1, 8'hFF, 1'b0);
        hold(4, 1'b0, 8'hFF, 1'b0);
        hold(3, 1'b1, 8'h00, 1'b0);

        // Full ramp of LED0 then a long window at full brightness
        hold(40, 1'b0, 8'h01, 1'b0);
        hold(300, 1'b0, 8'h01, 1'b0);
        hold(30, 1'b0, 8'h00, 1'b0);

        // Reversal partway up the ramp
        hold(13, 1'b0, 8'h01, 1'b0);
        hold(40, 1'b0, 8'h00, 1'b0);

        // Bypass with a fixed pattern, then back to PWM
        hold(6, 1'b0, 8'hA5, 1'b1);
        hold(30, 1'b0, 8'hA5, 1'b0);
        hold(5, 1'b0, 8'h5A, 1'b1);

        // Reset in the middle of a ramp
        hold(9, 1'b0, 8'hFF, 1'b0);
        hold(1, 1'b1, 8'hFF, 1'b0);
        hold(20, 1'b0, 8'hFF, 1'b0);

        // Randomised targets, bypass toggles and occasional resets
        for (int n = 0; n < 120; n++) begin
            pat = 8'($urandom);
            if ($urandom_range(0, 3) == 0) pat = pattern_in ^ (8'd1 << $urandom_range(0, 7));
            byp = ($urandom_range(0, 7) == 0);
            len = $urandom_range(1, 40);
            hold(len, 1'b0, pat, byp);
            if ($urandom_range(0, 15) == 0) hold(1, 1'b1, pat, byp);
        end

        @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got=%0d expected=0 leftover entries", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
